// File: rtl/exec_unit_mc.sv
// -----------------------------------------------------------------------------
// exec_unit_mc
//   Multi-cycle execution unit: NUM_REGS general registers, an ACC_WIDTH
//   accumulator, a valid/ready instruction handshake, iterative shift-by-N
//   (SHL/SHR) and iterative shift-add multiply (MUL).
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous, active-high reset
//   instr_valid  instruction present on opcode/rs/imm
//   instr_ready  unit can accept (high only in IDLE)
//   opcode       operation code
//   rs           source/destination register index
//   imm          immediate / shift amount / multiplier
//   cpu_out      registered output value (written by OUT)
//   out_valid    one-cycle pulse when cpu_out is updated
//   skip_next    one-cycle pulse asking fetch to skip the next instruction
//   zero         combinational: accumulator == 0
//   overflow     registered carry/borrow of the last ADD/SUB/MUL
//
// Build option
//   EXEC_SAT_EN  when defined, ADD saturates to all-ones on carry and SUB
//                saturates to zero on borrow; overflow still reports the cause.
// -----------------------------------------------------------------------------
module exec_unit_mc #(
    parameter int DATA_WIDTH = 4,
    parameter int ACC_WIDTH  = 8,
    parameter int NUM_REGS   = 4,
    parameter int REG_IDX_W  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [3:0]            opcode,
    input  logic [REG_IDX_W-1:0]  rs,
    input  logic [DATA_WIDTH-1:0] imm,
    output logic [ACC_WIDTH-1:0]  cpu_out,
    output logic                  out_valid,
    output logic                  skip_next,
    output logic                  zero,
    output logic                  overflow
);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_MUL} state_t;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0, OP_LDI = 4'h1, OP_ADD = 4'h2, OP_SUB  = 4'h3,
        OP_AND  = 4'h4, OP_OR  = 4'h5, OP_XOR = 4'h6, OP_INV  = 4'h7,
        OP_CLR  = 4'h8, OP_SHL = 4'h9, OP_SHR = 4'hA, OP_MUL  = 4'hB,
        OP_OUT  = 4'hC, OP_SNZ = 4'hD, OP_MOVA = 4'hE, OP_RSV = 4'hF
    } op_t;

    // Wide enough for any imm shift count and for the value DATA_WIDTH.
    localparam int CNT_W = DATA_WIDTH;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0]   regs_d [NUM_REGS];
    logic [ACC_WIDTH-1:0]    acc_q, acc_d;
    logic [ACC_WIDTH-1:0]    cpu_out_q, cpu_out_d;
    logic                    out_valid_q, out_valid_d;
    logic                    skip_q, skip_d;
    logic                    ovf_q, ovf_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    dir_left_q, dir_left_d;
    logic [ACC_WIDTH-1:0]    mcand_q, mcand_d;
    logic [DATA_WIDTH-1:0]   mplier_q, mplier_d;

    logic                    accept;
    logic [ACC_WIDTH-1:0]    operand;
    logic [ACC_WIDTH:0]      sum;
    logic [ACC_WIDTH:0]      diff;

    assign accept  = instr_valid && (state_q == S_IDLE);
    assign operand = ACC_WIDTH'(regs_q[rs]);
    assign sum     = {1'b0, acc_q} + {1'b0, operand};
    assign diff    = {1'b0, acc_q} - {1'b0, operand};   // MSB is the borrow

    always_comb begin
        state_d     = state_q;
        regs_d      = regs_q;
        acc_d       = acc_q;
        cpu_out_d   = cpu_out_q;
        out_valid_d = 1'b0;
        skip_d      = 1'b0;
        ovf_d       = ovf_q;
        cnt_d       = cnt_q;
        dir_left_d  = dir_left_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (op_t'(opcode))
                        OP_LDI: regs_d[rs] = imm;
                        OP_ADD: begin
                            ovf_d = sum[ACC_WIDTH];
`ifdef EXEC_SAT_EN
                            acc_d = sum[ACC_WIDTH] ? '1 : sum[ACC_WIDTH-1:0];
`else
                            acc_d = sum[ACC_WIDTH-1:0];
`endif
                        end
                        OP_SUB: begin
                            ovf_d = diff[ACC_WIDTH];
`ifdef EXEC_SAT_EN
                            acc_d = diff[ACC_WIDTH] ? '0 : diff[ACC_WIDTH-1:0];
`else
                            acc_d = diff[ACC_WIDTH-1:0];
`endif
                        end
                        OP_AND: acc_d = acc_q & operand;
                        OP_OR:  acc_d = acc_q | operand;
                        OP_XOR: acc_d = acc_q ^ operand;
                        OP_INV: acc_d = ~acc_q;
                        OP_CLR: begin
                            acc_d = '0;
                            ovf_d = 1'b0;
                        end
                        OP_SHL, OP_SHR: begin
                            // A zero count completes in the accept cycle.
                            dir_left_d = (op_t'(opcode) == OP_SHL);
                            cnt_d      = CNT_W'(imm);
                            if (imm != '0) state_d = S_SHIFT;
                        end
                        OP_MUL: begin
                            acc_d    = '0;
                            mcand_d  = operand;
                            mplier_d = imm;
                            cnt_d    = CNT_W'(DATA_WIDTH);
                            state_d  = S_MUL;
                        end
                        OP_OUT: begin
                            cpu_out_d   = acc_q;
                            out_valid_d = 1'b1;
                        end
                        OP_SNZ:  skip_d = (acc_q != '0);
                        OP_MOVA: regs_d[rs] = acc_q[DATA_WIDTH-1:0];
                        default: ;  // NOP and reserved opcode
                    endcase
                end
            end
            S_SHIFT: begin
                acc_d = dir_left_q ? (acc_q << 1) : (acc_q >> 1);
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = S_IDLE;
            end
            S_MUL: begin
                // mcand_q is kept pre-shifted, so it equals multiplicand << step.
                if (mplier_q[0]) acc_d = acc_q + mcand_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_IDLE;
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            acc_q       <= '0;
            cpu_out_q   <= '0;
            out_valid_q <= 1'b0;
            skip_q      <= 1'b0;
            ovf_q       <= 1'b0;
            cnt_q       <= '0;
            dir_left_q  <= 1'b0;
            mcand_q     <= '0;
            mplier_q    <= '0;
        end else begin
            state_q     <= state_d;
            regs_q      <= regs_d;
            acc_q       <= acc_d;
            cpu_out_q   <= cpu_out_d;
            out_valid_q <= out_valid_d;
            skip_q      <= skip_d;
            ovf_q       <= ovf_d;
            cnt_q       <= cnt_d;
            dir_left_q  <= dir_left_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
        end
    end

    assign instr_ready = (state_q == S_IDLE);
    assign cpu_out     = cpu_out_q;
    assign out_valid   = out_valid_q;
    assign skip_next   = skip_q;
    assign overflow    = ovf_q;
    assign zero        = (acc_q == '0);

endmodule

// File: tb/tb_exec_unit_mc.sv
// -----------------------------------------------------------------------------
// tb_exec_unit_mc
//   Directed, table-driven bench for exec_unit_mc with default parameters.
//   Inputs are driven and outputs sampled on the falling clock edge.
//   Expected values follow EXEC_SAT_EN when it is defined for the build.
// -----------------------------------------------------------------------------
module tb_exec_unit_mc;

    logic       clk = 1'b0;
    logic       reset;
    logic       instr_valid;
    logic       instr_ready;
    logic [3:0] opcode;
    logic [1:0] rs;
    logic [3:0] imm;
    logic [7:0] cpu_out;
    logic       out_valid;
    logic       skip_next;
    logic       zero;
    logic       overflow;

    int errors = 0;
    int checks = 0;

`ifdef EXEC_SAT_EN
    localparam logic [7:0] E_ADD18 = 8'hFF;
    localparam logic [7:0] E_SUB   = 8'h00;
    localparam logic [7:0] E_AND   = 8'h0D;
`else
    localparam logic [7:0] E_ADD18 = 8'h0E;
    localparam logic [7:0] E_SUB   = 8'hF4;
    localparam logic [7:0] E_AND   = 8'h09;
`endif

    exec_unit_mc #(
        .DATA_WIDTH (4),
        .ACC_WIDTH  (8),
        .NUM_REGS   (4),
        .REG_IDX_W  (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .opcode      (opcode),
        .rs          (rs),
        .imm         (imm),
        .cpu_out     (cpu_out),
        .out_valid   (out_valid),
        .skip_next   (skip_next),
        .zero        (zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0] op;
        logic [1:0] r;
        logic [3:0] i;
        bit         chk;   // compare cpu_out/overflow/zero for this vector
        logic [7:0] cpu;
        bit         ov;
        bit         skip;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic [3:0] op, input logic [1:0] r,
                                input logic [3:0] i, input bit chk,
                                input logic [7:0] cpu, input bit ov, input bit skip);
        vec_t v;
        v.op = op; v.r = r; v.i = i; v.chk = chk; v.cpu = cpu; v.ov = ov; v.skip = skip;
        tbl.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called on a falling edge; returns on the falling edge after the accepting edge.
    task automatic issue(input logic [3:0] op, input logic [1:0] r, input logic [3:0] i);
        int unsigned n = 0;
        while (!instr_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", 32'(instr_ready), 32'd1);
        instr_valid = 1'b1;
        opcode      = op;
        rs          = r;
        imm         = i;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        opcode      = 4'h0;
    endtask

    task automatic count_busy(output int unsigned n);
        n = 0;
        while (!instr_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        int unsigned busy;

        reset       = 1'b1;
        instr_valid = 1'b0;
        opcode      = 4'h0;
        rs          = 2'd0;
        imm         = 4'h0;

        // Vectors: op, rs, imm, chk, cpu_out, overflow, skip_next
        add(4'h1, 2'd1, 4'd9,  0, 8'h00, 0, 0);   // LDI r1,9
        add(4'h2, 2'd1, 4'd0,  0, 8'h00, 0, 0);   // ADD r1
        add(4'hC, 2'd0, 4'd0,  1, 8'h09, 0, 0);   // OUT -> 09
        add(4'h8, 2'd0, 4'd0,  0, 8'h00, 0, 0);   // CLR
        add(4'h1, 2'd2, 4'd15, 0, 8'h00, 0, 0);   // LDI r2,15
        for (int k = 0; k < 18; k++)
            add(4'h2, 2'd2, 4'd0, 0, 8'h00, 0, 0); // ADD r2 x18
        add(4'hC, 2'd0, 4'd0,  1, E_ADD18, 1, 0); // OUT: wrapped or saturated
        add(4'h8, 2'd0, 4'd0,  0, 8'h00, 0, 0);   // CLR clears overflow
        add(4'hC, 2'd0, 4'd0,  1, 8'h00, 0, 0);
        add(4'h1, 2'd1, 4'd3,  0, 8'h00, 0, 0);   // LDI r1,3
        add(4'h2, 2'd1, 4'd0,  0, 8'h00, 0, 0);   // acc=3
        add(4'h9, 2'd0, 4'd5,  0, 8'h00, 0, 0);   // SHL 5
        add(4'hC, 2'd0, 4'd0,  1, 8'h60, 0, 0);
        add(4'hA, 2'd0, 4'd0,  0, 8'h00, 0, 0);   // SHR 0
        add(4'hC, 2'd0, 4'd0,  1, 8'h60, 0, 0);
        add(4'hA, 2'd0, 4'd3,  0, 8'h00, 0, 0);   // SHR 3
        add(4'hC, 2'd0, 4'd0,  1, 8'h0C, 0, 0);
        add(4'h1, 2'd3, 4'd13, 0, 8'h00, 0, 0);   // LDI r3,13
        add(4'h8, 2'd0, 4'd0,  0, 8'h00, 0, 0);   // CLR
        add(4'hB, 2'd3, 4'd11, 0, 8'h00, 0, 0);   // MUL r3,11
        add(4'hC, 2'd0, 4'd0,  1, 8'h8F, 0, 0);
        add(4'hE, 2'd0, 4'd0,  0, 8'h00, 0, 0);   // MOVA r0 -> 0xF
        add(4'h8, 2'd0, 4'd0,  0, 8'h00, 0, 0);
        add(4'h2, 2'd0, 4'd0,  0, 8'h00, 0, 0);   // ADD r0
        add(4'hC, 2'd0, 4'd0,  1, 8'h0F, 0, 0);
        add(4'hD, 2'd0, 4'd0,  0, 8'h00, 0, 1);   // SNZ, acc=15 -> skip
        add(4'h8, 2'd0, 4'd0,  0, 8'h00, 0, 0);
        add(4'hD, 2'd0, 4'd0,  0, 8'h00, 0, 0);   // SNZ, acc=0 -> no skip
        add(4'h1, 2'd1, 4'd1,  0, 8'h00, 0, 0);   // LDI r1,1
        add(4'h2, 2'd1, 4'd0,  0, 8'h00, 0, 0);   // acc=1
        add(4'hD, 2'd0, 4'd0,  0, 8'h00, 0, 1);   // SNZ -> skip
        add(4'h3, 2'd3, 4'd0,  0, 8'h00, 0, 0);   // SUB r3: 1-13 borrows
        add(4'hC, 2'd0, 4'd0,  1, E_SUB, 1, 0);
        add(4'h7, 2'd0, 4'd0,  0, 8'h00, 0, 0);   // INV
        add(4'h4, 2'd3, 4'd0,  0, 8'h00, 0, 0);   // AND r3
        add(4'hC, 2'd0, 4'd0,  1, E_AND, 1, 0);   // overflow unchanged
        add(4'h5, 2'd2, 4'd0,  0, 8'h00, 0, 0);   // OR r2 -> 0F
        add(4'h6, 2'd1, 4'd0,  0, 8'h00, 0, 0);   // XOR r1 -> 0E
        add(4'hF, 2'd2, 4'd7,  0, 8'h00, 0, 0);   // reserved
        add(4'h0, 2'd1, 4'd3,  0, 8'h00, 0, 0);   // NOP
        add(4'hC, 2'd0, 4'd0,  1, 8'h0E, 1, 0);
        add(4'hB, 2'd1, 4'd3,  0, 8'h00, 0, 0);   // MUL r1(=1),3 clears overflow
        add(4'hC, 2'd0, 4'd0,  1, 8'h03, 0, 0);

        // Reset state
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_cpu_out",   32'(cpu_out),     32'h0);
        check("rst_out_valid", 32'(out_valid),   32'h0);
        check("rst_skip",      32'(skip_next),   32'h0);
        check("rst_overflow",  32'(overflow),    32'h0);
        check("rst_ready",     32'(instr_ready), 32'h1);
        check("rst_zero",      32'(zero),        32'h1);

        foreach (tbl[idx]) begin
            issue(tbl[idx].op, tbl[idx].r, tbl[idx].i);
            check($sformatf("v%0d_out_valid", idx), 32'(out_valid), 32'(tbl[idx].op == 4'hC));
            check($sformatf("v%0d_skip", idx), 32'(skip_next), 32'(tbl[idx].skip));
            if (tbl[idx].chk) begin
                check($sformatf("v%0d_cpu_out", idx), 32'(cpu_out), 32'(tbl[idx].cpu));
                check($sformatf("v%0d_overflow", idx), 32'(overflow), 32'(tbl[idx].ov));
                check($sformatf("v%0d_zero", idx), 32'(zero), 32'(tbl[idx].cpu == 8'h00));
            end
        end
        // Pulse lasts exactly one cycle
        @(negedge clk);
        check("out_valid_drop", 32'(out_valid), 32'h0);

        // SHL timing: acc=3 here, busy for 5 cycles after accept
        issue(4'h9, 2'd0, 4'd5);
        count_busy(busy);
        check("shl5_busy", busy, 32'd5);
        issue(4'hC, 2'd0, 4'd0);
        check("shl5_result", 32'(cpu_out), 32'h60);

        // SHR 0: ready again immediately after accept
        issue(4'hA, 2'd0, 4'd0);
        check("shr0_ready", 32'(instr_ready), 32'h1);

        // MUL timing: DATA_WIDTH busy cycles
        issue(4'hB, 2'd3, 4'd11);
        count_busy(busy);
        check("mul_busy", busy, 32'd4);

        // Reset during the 2nd MUL cycle aborts and clears acc
        issue(4'hB, 2'd3, 4'd11);
        @(negedge clk);
        check("mul_mid_zero",  32'(zero),        32'h0);   // acc=13 after step 0
        check("mul_mid_ready", 32'(instr_ready), 32'h0);
        reset = 1'b1;
        #1;
        check("abort_zero",     32'(zero),        32'h1);
        check("abort_ready",    32'(instr_ready), 32'h1);
        check("abort_cpu_out",  32'(cpu_out),     32'h0);
        check("abort_overflow", 32'(overflow),    32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        issue(4'h2, 2'd3, 4'd0);   // r3 cleared by reset, acc stays 0
        issue(4'hC, 2'd0, 4'd0);
        check("post_rst_cpu_out",   32'(cpu_out),   32'h0);
        check("post_rst_out_valid", 32'(out_valid), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
